// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: FSM encoding,
// datapath widths and timing constants.
package add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 8;
  localparam int ADD_LATENCY     = 3;
  localparam int OP_W            = 4;
  localparam int SUM_W           = 8;

  // Width of a counter that must reach t-1; never narrower than one bit.
  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Bundle of requester-side and adder-side signals around add_arbiter.
interface add_arbiter_if;
  import add_arbiter_pkg::*;

  // Requester: holds reqN with stable aN/bN until grantN; grantN stays high
  // through the single-cycle doneN pulse (result/err valid with doneN).
  // Adder: samples add_a/add_b on add_start, answers with add_done + add_sum.
  logic             req0;
  logic             req1;
  logic [OP_W-1:0]  a0;
  logic [OP_W-1:0]  b0;
  logic [OP_W-1:0]  a1;
  logic [OP_W-1:0]  b1;
  logic             grant0;
  logic             grant1;
  logic             done0;
  logic             done1;
  logic [SUM_W-1:0] result;
  logic             err;
  logic             add_start;
  logic [OP_W-1:0]  add_a;
  logic [OP_W-1:0]  add_b;
  logic             add_done;
  logic [SUM_W-1:0] add_sum;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, add_done, add_sum,
    output grant0, grant1, done0, done1, result, err, add_start, add_a, add_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, add_done, add_sum,
    input  grant0, grant1, done0, done1, result, err, add_start, add_a, add_b
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the requester not granted last wins a tie.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic sel,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    sel   = 1'b0;
    if (req0 && req1) begin
      sel = ~last;
    end else if (req1) begin
      sel = 1'b1;
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle adder, with a bounded
// wait for the adder's answer and an error flag on timeout.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  add_arbiter_if.slave bus,
  output arb_state_e   dbg_state
);

  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             add_start_q, add_start_d;
  logic [OP_W-1:0]  add_a_q, add_a_d;
  logic [OP_W-1:0]  add_b_q, add_b_d;
  logic [SUM_W-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             pick_sel;
  logic             pick_valid;

  rr_pick2 u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (last_q),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    grant0_d    = grant0_q;
    grant1_d    = grant1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    add_start_d = 1'b0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    result_d    = result_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_sel;
          add_a_d     = pick_sel ? bus.a1 : bus.a0;
          add_b_d     = pick_sel ? bus.b1 : bus.b0;
          grant0_d    = ~pick_sel;
          grant1_d    = pick_sel;
          add_start_d = 1'b1;
          state_d     = START;
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      // add_done is tested first so an answer on the last allowed cycle wins.
      WAIT: begin
        if (bus.add_done) begin
          result_d = bus.add_sum;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (state_d == RESP) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
        end
      end

      RESP: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        last_d   = owner_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      grant0_q    <= grant0_d;
      grant1_q    <= grant1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      add_start_q <= add_start_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      result_q    <= result_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.grant0    = grant0_q;
  assign bus.grant1    = grant1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed-plus-random bench for add_arbiter with a behavioural adder and a
// transaction-level model of arbitration, latency and result.
module tb_add_arbiter;
  import add_arbiter_pkg::*;

  localparam int TIMEOUT = DEFAULT_TIMEOUT;
  localparam int MAX_CYC = 40;

  logic       clk = 1'b0;
  logic       rst;
  arb_state_e dbg_state;

  add_arbiter_if bus ();

  int tests       = 0;
  int fails       = 0;
  int add_lat     = ADD_LATENCY;
  int start_count = 0;
  bit model_last  = 1'b1;

  add_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Adder: answers add_lat cycles after the cycle add_start is seen (0 = never).
  initial begin
    int cd;
    logic [3:0] op_a;
    logic [3:0] op_b;
    cd = 0;
    op_a = '0;
    op_b = '0;
    bus.add_done = 1'b0;
    bus.add_sum  = '0;
    forever begin
      @(negedge clk);
      if (bus.add_start === 1'b1) begin
        start_count++;
        cd   = add_lat;
        op_a = bus.add_a;
        op_b = bus.add_b;
        bus.add_done = 1'b0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.add_done = 1'b1;
          bus.add_sum  = {4'h0, op_a} + {4'h0, op_b};
        end
      end else begin
        bus.add_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.grant0, bus.grant1, bus.done0, bus.done1, bus.add_start,
                bus.err, bus.add_a, bus.add_b, bus.result});
  endfunction

  task automatic rand_ops();
    bus.a0 = 4'($urandom_range(0, 15));
    bus.b0 = 4'($urandom_range(0, 15));
    bus.a1 = 4'($urandom_range(0, 15));
    bus.b1 = 4'($urandom_range(0, 15));
  endtask

  // Called during the IDLE cycle in which the request is presented.
  task automatic txn(input string tag, input int lat, input bit hold, input bit drop_at2);
    bit         own;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [7:0] eres;
    bit         eerr;
    int         elat;
    int         k;
    bit         seen;
    bit         stable;
    int         starts0;

    if (bus.req0 && bus.req1) own = ~model_last;
    else                      own = bus.req1;
    ea = own ? bus.a1 : bus.a0;
    eb = own ? bus.b1 : bus.b0;
    add_lat = lat;
    if (lat >= 1 && lat <= TIMEOUT) begin
      eres = {4'h0, ea} + {4'h0, eb};
      eerr = 1'b0;
      elat = lat + 2;
    end else begin
      eres = 8'h00;
      eerr = 1'b1;
      elat = TIMEOUT + 2;
    end

    starts0 = start_count;
    seen    = 1'b0;
    stable  = 1'b1;
    k       = 0;
    while (!seen && k < MAX_CYC) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({tag, " grant_owner"}, 32'(own ? bus.grant1 : bus.grant0), 32'd1);
        check({tag, " grant_other"}, 32'(own ? bus.grant0 : bus.grant1), 32'd0);
        check({tag, " add_start"}, 32'(bus.add_start), 32'd1);
      end
      if (k == 2 && drop_at2) begin
        if (own) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
      end
      if (bus.add_a !== ea || bus.add_b !== eb) stable = 1'b0;
      seen = (bus.done0 === 1'b1) || (bus.done1 === 1'b1);
    end

    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, 32'(k), 32'(elat));
      check({tag, " done_owner"}, 32'(own ? bus.done1 : bus.done0), 32'd1);
      check({tag, " done_other"}, 32'(own ? bus.done0 : bus.done1), 32'd0);
      check({tag, " result"}, 32'(bus.result), 32'(eres));
      check({tag, " err"}, 32'(bus.err), 32'(eerr));
      check({tag, " grant_held"}, 32'(own ? bus.grant1 : bus.grant0), 32'd1);
      check({tag, " operands_stable"}, 32'(stable), 32'd1);
      check({tag, " start_count"}, 32'(start_count - starts0), 32'd1);
    end
    if (!hold) begin
      if (own) bus.req1 = 1'b0;
      else     bus.req0 = 1'b0;
    end
    @(negedge clk);
    check({tag, " done_cleared"}, 32'({bus.done0, bus.done1}), 32'd0);
    check({tag, " grant_cleared"}, 32'({bus.grant0, bus.grant1}), 32'd0);
    check({tag, " back_idle"}, 32'(dbg_state), 32'(IDLE));
    model_last = own;
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0 = '0;
    bus.b0 = '0;
    bus.a1 = '0;
    bus.b1 = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", out_vec(), 32'd0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Nominal 3 + 4 transaction on requester 0.
    bus.a0 = 4'd3;
    bus.b0 = 4'd4;
    bus.req0 = 1'b1;
    txn("basic", ADD_LATENCY, 1'b0, 1'b0);
    check("basic sum", 32'(bus.result), 32'h07);

    // Both held from reset: 0 first, then alternation.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    rand_ops();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      txn($sformatf("alt%0d", i), ADD_LATENCY, 1'b1, 1'b0);
      rand_ops();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      bus.req0 = r[0];
      bus.req1 = r[1];
      rand_ops();
      txn($sformatf("rand%0d", i), int'($urandom_range(1, 4)), 1'b0, 1'b0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end

    rand_ops();
    bus.req1 = 1'b1;
    txn("timeout", 0, 1'b0, 1'b0);

    rand_ops();
    bus.req0 = 1'b1;
    txn("late_in_resp", TIMEOUT + 1, 1'b0, 1'b0);

    rand_ops();
    bus.req1 = 1'b1;
    txn("late_in_idle", TIMEOUT + 2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("hold result", 32'(bus.result), 32'h00);
    check("hold err", 32'(bus.err), 32'd1);

    rand_ops();
    bus.req1 = 1'b1;
    txn("drop_req1", ADD_LATENCY, 1'b0, 1'b1);

    bus.a0 = 4'd9;
    bus.b0 = 4'd6;
    bus.req0 = 1'b1;
    txn("coincident", TIMEOUT, 1'b0, 1'b0);

    // Abort a transaction stuck in WAIT with a reset pulse.
    add_lat = 0;
    bus.req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("rst_mid pre_state", 32'(dbg_state), 32'(WAIT));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid outputs", out_vec(), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    @(negedge clk);
    check("rst_mid first_state", 32'(dbg_state), 32'(IDLE));
    if (bus.done0 === 1'b1 || bus.done1 === 1'b1) saw_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done0 === 1'b1 || bus.done1 === 1'b1) saw_done = 1'b1;
    end
    check("rst_mid no_done", 32'(saw_done), 32'd0);
    model_last = 1'b1;

    rand_ops();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    txn("post_rst_tie", ADD_LATENCY, 1'b0, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);

    rand_ops();
    bus.req0 = 1'b1;
    txn("post_rst_req0", ADD_LATENCY, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
